// File: rtl/flash_bpi_pkg.sv
// Shared types and elaboration helpers for the BPI flash access engine.
package flash_bpi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD,
        WR,
        HOLD,
        RSP
    } state_t;

    function automatic int unsigned max_of5(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Width of the phase counter: must hold the largest reload value without wrapping.
    function automatic int unsigned cnt_width(input int unsigned setup_cyc, input int unsigned rd_cyc,
                                              input int unsigned wr_cyc, input int unsigned hold_cyc,
                                              input int unsigned wait_timeout);
        return $clog2(max_of5(setup_cyc, rd_cyc, wr_cyc, hold_cyc, wait_timeout) + 1);
    endfunction

    function automatic bit params_ok(input int unsigned setup_cyc, input int unsigned rd_cyc,
                                     input int unsigned wr_cyc, input int unsigned hold_cyc,
                                     input int unsigned wait_timeout);
        return (setup_cyc >= 1) && (rd_cyc >= 3) && (wr_cyc >= 1) &&
               (hold_cyc >= 1) && (wait_timeout >= 1);
    endfunction

endpackage

// File: rtl/flash_bpi_ctrl_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the raw level through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/flash_bpi_ctrl.sv
// Single-beat BPI parallel-NOR flash access engine: one request in, timed
// asynchronous bus cycle on the pins, exactly one response out.
module flash_bpi_ctrl
    import flash_bpi_pkg::*;
#(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned RD_CYC       = 8,
    parameter int unsigned WR_CYC       = 6,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [DATA_W-1:0] flash_dq_o,
    output logic              flash_dq_oe,
    input  logic [DATA_W-1:0] flash_dq_i,
    input  logic              flash_wait,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n
);

    if (!params_ok(SETUP_CYC, RD_CYC, WR_CYC, HOLD_CYC, WAIT_TIMEOUT)) begin : g_bad_params
        $error("flash_bpi_ctrl: timing parameter out of range");
    end

    localparam int unsigned CNT_W = cnt_width(SETUP_CYC, RD_CYC, WR_CYC, HOLD_CYC, WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(WAIT_TIMEOUT - 1);

    logic wait_s;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ext_q, ext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [ADDR_W-1:0] flash_addr_q, flash_addr_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;

    sync_bit u_wait_sync (
        .clk (CLK),
        .rst (RST),
        .d   (flash_wait),
        .q   (wait_s)
    );

    // State, phase counter, latched request and registered pin outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ext_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
            flash_addr_q <= '0;
            dq_o_q       <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ext_q        <= ext_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            dq_oe_q      <= dq_oe_d;
            flash_addr_q <= flash_addr_d;
            dq_o_q       <= dq_o_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // Next state: phase timing, wait extension/timeout and read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ext_d   = ext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LAST;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    ext_d = 1'b0;
                    if (write_q) begin
                        state_d = WR;
                        cnt_d   = WR_LAST;
                    end else begin
                        state_d = RD;
                        cnt_d   = RD_LAST;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Past the nominal strobe width the counter is reused as the
            // wait-extension budget; data is taken on the first wait-low cycle.
            RD: begin
                if (!ext_q && (cnt_q != '0)) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!wait_s) begin
                    rdata_d = flash_dq_i;
                    state_d = HOLD;
                    cnt_d   = HOLD_LAST;
                end else if (!ext_q) begin
                    ext_d = 1'b1;
                    cnt_d = TO_LAST;
                end else if (cnt_q == '0) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                    cnt_d   = HOLD_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LAST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = RSP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin outputs decoded from the next state so every strobe leaves a flop
    // aligned with the state it belongs to.
    always_comb begin
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        dq_oe_d      = 1'b0;
        flash_addr_d = '0;
        dq_o_d       = '0;
        req_ready_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        unique case (state_d)
            IDLE: begin
                req_ready_d = 1'b1;
            end
            SETUP, HOLD: begin
                ce_n_d       = 1'b0;
                flash_addr_d = addr_d;
                dq_oe_d      = write_d;
                dq_o_d       = write_d ? wdata_d : '0;
            end
            RD: begin
                ce_n_d       = 1'b0;
                oe_n_d       = 1'b0;
                flash_addr_d = addr_d;
            end
            WR: begin
                ce_n_d       = 1'b0;
                we_n_d       = 1'b0;
                flash_addr_d = addr_d;
                dq_oe_d      = 1'b1;
                dq_o_d       = wdata_d;
            end
            RSP: begin
                rsp_valid_d = 1'b1;
            end
            default: begin
                req_ready_d = 1'b0;
            end
        endcase
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign flash_addr  = flash_addr_q;
    assign flash_dq_o  = dq_o_q;
    assign flash_dq_oe = dq_oe_q;
    assign flash_ce_n  = ce_n_q;
    assign flash_oe_n  = oe_n_q;
    assign flash_we_n  = we_n_q;

endmodule

// File: tb/tb_flash_bpi_ctrl.sv
// Scoreboard bench for flash_bpi_ctrl with a pin-level flash device model.
`timescale 1ns/1ps
module tb_flash_bpi_ctrl;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [23:0] flash_addr;
    logic [15:0] flash_dq_o;
    logic        flash_dq_oe;
    logic [15:0] flash_dq_i;
    logic        flash_wait;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;

    flash_bpi_ctrl #(
        .ADDR_W       (24),
        .DATA_W       (16),
        .SETUP_CYC    (2),
        .RD_CYC       (8),
        .WR_CYC       (6),
        .HOLD_CYC     (2),
        .WAIT_TIMEOUT (255)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .flash_addr  (flash_addr),
        .flash_dq_o  (flash_dq_o),
        .flash_dq_oe (flash_dq_oe),
        .flash_dq_i  (flash_dq_i),
        .flash_wait  (flash_wait),
        .flash_ce_n  (flash_ce_n),
        .flash_oe_n  (flash_oe_n),
        .flash_we_n  (flash_we_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        int unsigned lat;
        int unsigned oe_cyc;
        int unsigned we_cyc;
        int unsigned dqoe_cyc;
    } exp_t;

    exp_t sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [15:0] dev_mem [logic [23:0]];
    logic [15:0] ref_mem [logic [23:0]];

    function automatic logic [15:0] dflt(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'hA55A;
    endfunction

    function automatic logic [15:0] ref_read(input logic [23:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Flash device: drives data while output-enabled, stores on we_n rising under ce_n.
    logic prev_we_n = 1'b1;
    always @(negedge CLK) begin
        if (!flash_oe_n && !flash_ce_n)
            flash_dq_i = dev_mem.exists(flash_addr) ? dev_mem[flash_addr] : dflt(flash_addr);
        else
            flash_dq_i = 16'h0000;
        if (!prev_we_n && flash_we_n && !flash_ce_n && flash_dq_oe)
            dev_mem[flash_addr] = flash_dq_o;
        prev_we_n = flash_we_n;
    end

    // Response consumer: random back-pressure, or forced stall cycles.
    int unsigned stall_cyc = 0;
    always @(posedge CLK) begin
        #1;
        if (stall_cyc > 0) begin
            rsp_ready = 1'b0;
            stall_cyc--;
        end else begin
            rsp_ready = ($urandom_range(3) != 0);
        end
    end

    // Monitor: measures each access from accept to response and checks it.
    bit          busy = 1'b0;
    bit          seen_v;
    int unsigned cyc, oe_c, we_c, dqoe_c, first_v, viol;
    logic [15:0] hold_rd;
    logic        hold_err;
    exp_t        e_mon;
    always @(negedge CLK) begin
        if (RST) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                cyc++;
                if (!flash_oe_n) oe_c++;
                if (!flash_we_n) we_c++;
                if (flash_dq_oe) dqoe_c++;
                if (!flash_oe_n && !flash_we_n) viol++;
                if (flash_dq_oe && !flash_oe_n) viol++;
                if (req_ready) viol++;
                if (rsp_valid) begin
                    if (!seen_v) begin
                        seen_v   = 1'b1;
                        first_v  = cyc;
                        hold_rd  = rsp_rdata;
                        hold_err = rsp_err;
                    end else if (rsp_rdata !== hold_rd || rsp_err !== hold_err) begin
                        viol++;
                    end
                    if (rsp_ready) begin
                        busy = 1'b0;
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_rsp: got response with rdata 0x%0h, required none", rsp_rdata);
                        end else begin
                            e_mon = sb.pop_front();
                            chk("rsp_rdata", 32'(rsp_rdata), 32'(e_mon.rdata));
                            chk("rsp_err", 32'(rsp_err), 32'(e_mon.err));
                            chk("latency", first_v, e_mon.lat);
                            chk("oe_low_cycles", oe_c, e_mon.oe_cyc);
                            chk("we_low_cycles", we_c, e_mon.we_cyc);
                            chk("dq_oe_cycles", dqoe_c, e_mon.dqoe_cyc);
                            chk("protocol_violations", viol, 0);
                        end
                    end
                end
            end
            if (req_valid && req_ready) begin
                busy   = 1'b1;
                cyc    = 0;
                oe_c   = 0;
                we_c   = 0;
                dqoe_c = 0;
                viol   = 0;
                seen_v = 1'b0;
            end
        end
    end

    // Issue one request; wait_hi = cycles flash_wait is held high from accept.
    task automatic issue(input bit wr, input logic [23:0] a, input logic [15:0] d,
                         input int unsigned wait_hi);
        exp_t        e;
        int unsigned ext;
        bit          acc;
        if (wr) begin
            e.rdata    = 16'h0000;
            e.err      = 1'b0;
            e.lat      = 11;
            e.oe_cyc   = 0;
            e.we_cyc   = 6;
            e.dqoe_cyc = 10;
            ref_mem[a] = d;
        end else begin
            // Wait is seen by the engine two cycles late; the 8-cycle strobe
            // ends at cycle 10 after accept, so every cycle it is still seen
            // high beyond that stretches the access by one.
            ext = (wait_hi > 8) ? wait_hi - 8 : 0;
            if (ext > 255) begin
                e.rdata = 16'h0000;
                e.err   = 1'b1;
                ext     = 255;
            end else begin
                e.rdata = ref_read(a);
                e.err   = 1'b0;
            end
            e.lat      = 13 + ext;
            e.oe_cyc   = 8 + ext;
            e.we_cyc   = 0;
            e.dqoe_cyc = 0;
        end
        sb.push_back(e);
        @(posedge CLK);
        #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        acc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got req_ready=0 for 2000 cycles, required 1");
            void'(sb.pop_back());
            req_valid = 1'b0;
        end else begin
            if (wait_hi > 0) flash_wait = 1'b1;
            @(posedge CLK);
            #1;
            req_valid = 1'b0;
            if (wait_hi > 0) begin
                repeat (wait_hi - 1) @(negedge CLK);
                @(negedge CLK);
                flash_wait = 1'b0;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion within time limit, required completion");
        $fatal(1);
    end

    logic [15:0] old_val;
    bit          saw_we;
    bit          wr_r;
    logic [23:0] a_r;
    logic [15:0] d_r;
    int unsigned w_r;

    initial begin
        RST        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        flash_wait = 1'b0;
        flash_dq_i = '0;
        dev_mem[24'h00ABCD] = 16'h1234;
        ref_mem[24'h00ABCD] = 16'h1234;
        #1 RST = 1'b1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_ce_n", 32'(flash_ce_n), 1);
        chk("rst_oe_n", 32'(flash_oe_n), 1);
        chk("rst_we_n", 32'(flash_we_n), 1);
        chk("rst_dq_oe", 32'(flash_dq_oe), 0);
        chk("rst_addr", 32'(flash_addr), 0);
        chk("rst_dq_o", 32'(flash_dq_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_reset", 32'(req_ready), 1);

        issue(1'b0, 24'h00ABCD, 16'h0000, 0);
        issue(1'b1, 24'h000010, 16'hBEEF, 0);
        issue(1'b0, 24'h000010, 16'h0000, 0);
        issue(1'b0, 24'h00ABCD, 16'h0000, 20);
        issue(1'b0, 24'h000010, 16'h0000, 400);
        issue(1'b0, 24'h000011, 16'h0000, 263);
        issue(1'b0, 24'h000012, 16'h0000, 264);
        issue(1'b1, 24'h000013, 16'h5A5A, 30);
        stall_cyc = 70;
        issue(1'b0, 24'h000013, 16'h0000, 0);
        repeat (80) @(negedge CLK);

        // Reset in the middle of a write strobe.
        old_val = ref_read(24'h000077);
        issue(1'b1, 24'h000077, 16'h1111, 0);
        saw_we = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (!flash_we_n) begin
                saw_we = 1'b1;
                break;
            end
        end
        chk("we_strobe_seen", 32'(saw_we), 1);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("midrst_we_n", 32'(flash_we_n), 1);
        chk("midrst_ce_n", 32'(flash_ce_n), 1);
        chk("midrst_dq_oe", 32'(flash_dq_oe), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_req_ready", 32'(req_ready), 0);
        sb.delete();
        ref_mem[24'h000077] = old_val;
        @(posedge CLK);
        #2 RST = 1'b0;
        issue(1'b0, 24'h000077, 16'h0000, 0);

        for (int n = 0; n < 40; n++) begin
            wr_r = 1'($urandom_range(1));
            a_r  = 24'h000100 | 24'($urandom_range(7));
            d_r  = 16'($urandom);
            w_r  = ($urandom_range(3) == 0) ? $urandom_range(30) : 0;
            issue(wr_r, a_r, d_r, w_r);
        end

        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (sb.size() == 0 && !busy) break;
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
